// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch-address generator (reset/enable/stall encodings,
// default reset vector and increment, next-pc source select).
package pc_gen_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    localparam int unsigned DEFAULT_ADDR_W     = 32;
    localparam int unsigned DEFAULT_INST_BYTES = 4;
    localparam int unsigned DEFAULT_STALL_W    = 6;
    localparam logic [31:0] DEFAULT_RESET_VEC  = 32'h0000_0000;

    // Source of the next fetch address, resolved once per cycle by priority.
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_INC    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_PEND   = 3'd3,
        SEL_FLUSH  = 3'd4,
        SEL_START  = 3'd5
    } pc_sel_e;

endpackage : pc_gen_pkg

// File: rtl/pc_redirect_buf.sv
// Holds one redirect that arrived while fetch was stalled; targets are aligned on capture
// and a newer capture overwrites an older one.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned INST_BYTES = DEFAULT_INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic              pending_o,
    output logic [ADDR_W-1:0] pend_addr_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

    logic              pending_d, pending_q;
    logic [ADDR_W-1:0] pend_addr_d, pend_addr_q;

    always_comb begin
        pending_d   = pending_q;
        pend_addr_d = pend_addr_q;
        if (capture_i) begin
            pending_d   = 1'b1;
            pend_addr_d = target_i & ALIGN_MASK;
        end else if (clear_i) begin
            pending_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pending_o   = pending_q;
    assign pend_addr_o = pend_addr_q;

endmodule : pc_redirect_buf

// File: rtl/pc_gen.sv
// Fetch-address generator at the head of IF: drives pc/ce, advances per unstalled cycle,
// takes ID redirects and parks stalled ones. Optional exception flush via `PC_FLUSH_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC),
    parameter int unsigned       INST_BYTES = DEFAULT_INST_BYTES,
    parameter int unsigned       STALL_W    = DEFAULT_STALL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] pause,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
`ifdef PC_FLUSH_EN
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
`endif
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pend_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              ce_d, ce_q;
    logic              stall;
    logic              buf_capture, buf_clear;
    logic              pending;
    logic [ADDR_W-1:0] pend_addr;
    pc_sel_e           pc_sel;
    logic              unused_pause;

    // Only the IF stall bit matters here; the rest of the ctrl vector is for later stages.
    assign stall        = (pause[0] == STOP);
    assign unused_pause = ^pause;

    // Next-pc source, highest priority first.
    always_comb begin
        pc_sel      = SEL_HOLD;
        buf_capture = 1'b0;
        buf_clear   = 1'b0;
        if (ce_q == CHIP_DISABLE) begin
            pc_sel = SEL_START;
        end else
`ifdef PC_FLUSH_EN
        if (flush_i) begin
            pc_sel    = SEL_FLUSH;
            buf_clear = 1'b1;
        end else
`endif
        if (branch_flag_i && stall) begin
            pc_sel      = SEL_HOLD;
            buf_capture = 1'b1;
        end else if (branch_flag_i) begin
            pc_sel    = SEL_BRANCH;
            buf_clear = 1'b1;
        end else if (pending && !stall) begin
            pc_sel    = SEL_PEND;
            buf_clear = 1'b1;
        end else if (stall) begin
            pc_sel = SEL_HOLD;
        end else begin
            pc_sel = SEL_INC;
        end
    end

    always_comb begin
        pc_d = pc_q;
        ce_d = CHIP_ENABLE;
        unique case (pc_sel)
            SEL_START:  pc_d = RESET_VEC;
            SEL_INC:    pc_d = pc_q + PC_STEP;
            SEL_BRANCH: pc_d = branch_target_i & ALIGN_MASK;
            SEL_PEND:   pc_d = pend_addr;
`ifdef PC_FLUSH_EN
            SEL_FLUSH:  pc_d = new_pc_i & ALIGN_MASK;
`endif
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ce_q <= CHIP_DISABLE;
            pc_q <= RESET_VEC;
        end else begin
            ce_q <= ce_d;
            pc_q <= pc_d;
        end
    end

    pc_redirect_buf #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES)
    ) u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (buf_capture),
        .clear_i     (buf_clear),
        .target_i    (branch_target_i),
        .pending_o   (pending),
        .pend_addr_o (pend_addr)
    );

    assign pc              = pc_q;
    assign ce              = ce_q;
    assign redirect_pend_o = pending;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; flush vectors are included when built with `PC_FLUSH_EN.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pause;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
`ifdef PC_FLUSH_EN
    logic        flush_i;
    logic [31:0] new_pc_i;
`endif
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pend_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .pause           (pause),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
`ifdef PC_FLUSH_EN
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
`endif
        .pc              (pc),
        .ce              (ce),
        .redirect_pend_o (redirect_pend_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] e_pc,
                                input logic e_ce, input logic e_pend);
        check({tag, ".pc"},   pc, e_pc);
        check({tag, ".ce"},   32'(ce), 32'(e_ce));
        check({tag, ".pend"}, 32'(redirect_pend_o), 32'(e_pend));
    endtask

    initial begin
        rst = 1'b1; pause = '0; branch_flag_i = 1'b0; branch_target_i = '0;
`ifdef PC_FLUSH_EN
        flush_i = 1'b0; new_pc_i = '0;
`endif
        // Reset and start-up
        step(); step();
        expect_state("reset", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); expect_state("start", 32'h0, 1'b1, 1'b0);
        step(); check("inc1", pc, 32'h4);
        step(); check("inc2", pc, 32'h8);
        step(); check("inc3", pc, 32'hC);
        step(); check("inc4", pc, 32'h10);

        // Plain stall
        pause = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", pc, 32'h10);
        end
        pause = '0;
        step(); check("stall_release", pc, 32'h14);

        // Branch arriving during a stall is parked
        pause = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h100;
        step(); expect_state("park", 32'h14, 1'b1, 1'b1);
        branch_flag_i = 1'b0;
        step(); expect_state("park_hold", 32'h14, 1'b1, 1'b1);
        pause = '0;
        step(); expect_state("park_release", 32'h100, 1'b1, 1'b0);

        // Newer parked branch overwrites older
        pause = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h100;
        step(); check("ovw1.pend", 32'(redirect_pend_o), 32'h1);
        branch_target_i = 32'h200;
        step(); expect_state("ovw2", 32'h100, 1'b1, 1'b1);
        branch_flag_i = 1'b0; pause = '0;
        step(); expect_state("ovw_release", 32'h200, 1'b1, 1'b0);

        // Fresh unstalled branch beats a stored one
        pause = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h400;
        step(); expect_state("beat_park", 32'h200, 1'b1, 1'b1);
        pause = '0; branch_target_i = 32'h300;
        step(); expect_state("beat_new", 32'h300, 1'b1, 1'b0);
        branch_flag_i = 1'b0;
        step(); check("beat_inc", pc, 32'h304);

        // Wrap and alignment
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        step(); check("wrap_load", pc, 32'hFFFF_FFFC);
        branch_flag_i = 1'b0;
        step(); check("wrap", pc, 32'h0);
        branch_flag_i = 1'b1; branch_target_i = 32'h103;
        step(); check("align_br", pc, 32'h100);
        pause = 6'b000001; branch_target_i = 32'h207;
        step(); check("align_park_hold", pc, 32'h100);
        branch_flag_i = 1'b0; pause = '0;
        step(); check("align_park", pc, 32'h204);

        // Upper pause bits are ignored
        pause = 6'b111110;
        step(); check("upper_pause", pc, 32'h208);
        pause = '0;

        // Branch while chip disabled is discarded
        rst = 1'b1;
        step(); expect_state("rst2", 32'h0, 1'b0, 1'b0);
        rst = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h500;
        step(); expect_state("dis_branch", 32'h0, 1'b1, 1'b0);
        branch_flag_i = 1'b0;
        step(); expect_state("dis_after", 32'h4, 1'b1, 1'b0);

`ifdef PC_FLUSH_EN
        // Flush beats stall and clears a parked redirect
        pause = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h600;
        step(); check("fl_park.pend", 32'(redirect_pend_o), 32'h1);
        branch_flag_i = 1'b0; flush_i = 1'b1; new_pc_i = 32'h180;
        step(); expect_state("flush", 32'h180, 1'b1, 1'b0);
        flush_i = 1'b0;
        step(); check("flush_hold", pc, 32'h180);
        pause = '0;
`endif

        // Reset in the middle of a stalled redirect
        pause = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h700;
        step(); check("midrst_park.pend", 32'(redirect_pend_o), 32'h1);
        branch_flag_i = 1'b0; rst = 1'b1;
        step(); expect_state("midrst", 32'h0, 1'b0, 1'b0);
        rst = 1'b0; pause = '0;
        step(); expect_state("midrst_start", 32'h0, 1'b1, 1'b0);
        step(); expect_state("midrst_inc", 32'h4, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_gen
